// File: rtl/signed_delta_pkg.sv
// Shared types and constants for the signed delta decoder.
// Holds default widths, sample range limits and the output-stage state encoding.
package signed_delta_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DIFF_W = DEF_DATA_W + 1;
    localparam int DEF_IDX_W  = 8;

    localparam int SAMPLE_MAX = (2 ** (DEF_DATA_W - 1)) - 1;
    localparam int SAMPLE_MIN = -(2 ** (DEF_DATA_W - 1));

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/signed_sat_add.sv
// Combinational accumulate step: acc + diff (or diff alone on stream start), range-checked.
// Out-of-range handling saturates when SIGNED_DELTA_DEC_SAT_EN is defined, otherwise wraps.
module signed_sat_add
    import signed_delta_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIFF_W = DATA_W + 1
) (
    input  logic signed [DATA_W-1:0] acc_i,
    input  logic signed [DIFF_W-1:0] diff_i,
    input  logic                     first_i,
    output logic signed [DATA_W-1:0] result_o,
    output logic                     ovf_o
);

    localparam int SUM_W = DIFF_W + 1;
    localparam int MAX_I = (2 ** (DATA_W - 1)) - 1;
    localparam int MIN_I = -(2 ** (DATA_W - 1));
    localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(MAX_I);
    localparam logic signed [SUM_W-1:0] MIN_EXT = SUM_W'(MIN_I);

    logic signed [SUM_W-1:0] accExt;
    logic signed [SUM_W-1:0] diffExt;
    logic signed [SUM_W-1:0] sum;
    logic                    overMax;
    logic                    underMin;

    // One extra bit beyond the difference width makes the sum exact for any operands.
    always_comb begin
        accExt   = {{(SUM_W - DATA_W){acc_i[DATA_W-1]}}, acc_i};
        diffExt  = {diff_i[DIFF_W-1], diff_i};
        sum      = first_i ? diffExt : (accExt + diffExt);
        overMax  = (sum > MAX_EXT);
        underMin = (sum < MIN_EXT);
        ovf_o    = overMax | underMin;
`ifdef SIGNED_DELTA_DEC_SAT_EN
        if (overMax) begin
            result_o = DATA_W'(MAX_I);
        end else if (underMin) begin
            result_o = DATA_W'(MIN_I);
        end else begin
            result_o = sum[DATA_W-1:0];
        end
`else
        result_o = sum[DATA_W-1:0];
`endif
    end

endmodule

// File: rtl/signed_delta_decoder.sv
// Rebuilds a signed sample stream from signed differences through a one-entry output stage.
// Optional saturation on overflow is enabled by defining SIGNED_DELTA_DEC_SAT_EN.
module signed_delta_decoder
    import signed_delta_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIFF_W = DATA_W + 1,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIFF_W-1:0] in_diff,
    input  logic                     in_first,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_ovf,
    output logic [IDX_W-1:0]         out_idx
);

    state_e                    state_q;
    state_e                    state_d;
    logic                      inAccept;
    logic                      outAccept;
    logic signed [DATA_W-1:0]  acc_q;
    logic signed [DATA_W-1:0]  acc_d;
    logic                      ovf_q;
    logic                      ovf_d;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          idx_d;
    logic signed [DATA_W-1:0]  addResult;
    logic                      addOvf;

    signed_sat_add #(
        .DATA_W (DATA_W),
        .DIFF_W (DIFF_W)
    ) u_add (
        .acc_i    (acc_q),
        .diff_i   (in_diff),
        .first_i  (in_first),
        .result_o (addResult),
        .ovf_o    (addOvf)
    );

    assign inAccept  = in_valid & in_ready;
    assign outAccept = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (inAccept) state_d = FULL;
            FULL:    if (outAccept && !inAccept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = (state_q == EMPTY) | out_ready;
    end

    // The held output register doubles as the accumulator, so acc always matches the last emitted sample.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        idx_d = idx_q;
        if (inAccept) begin
            acc_d = addResult;
            ovf_d = addOvf;
            idx_d = in_first ? '0 : (idx_q + IDX_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            idx_q <= idx_d;
        end
    end

    assign out_sample = acc_q;
    assign out_ovf    = ovf_q;
    assign out_idx    = idx_q;

endmodule
